// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch sequencer states, default reset and
// exception entry addresses, and the sequential PC step.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] PC_STEP            = 32'd4;

endpackage

// File: rtl/pc_inc.sv
// Combinational sequential-PC incrementer; the 32-bit add wraps modulo 2^32.
module pc_inc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    assign pc_next = pc + PC_STEP;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: valid/ready fetch requests, branch/jump redirects with a
// one-cycle bubble. Define PC_SEQ_EXC_EN to add exception entry, eret and the EPC register.
module pc_sequencer
    import mips_pkg::*;
#(
`ifdef PC_SEQ_EXC_EN
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
`endif
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    input  logic        eret_valid,
    output logic [31:0] epc,
`endif
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        addr_err
);

    pc_state_e   state, state_n;
    logic [31:0] pc, pc_n, pc_plus;
    logic        addr_err_n;
    logic        fire;
`ifdef PC_SEQ_EXC_EN
    logic [31:0] epc_q, epc_n;
`endif

    pc_inc u_pc_inc (
        .pc      (pc),
        .pc_next (pc_plus)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            addr_err <= 1'b0;
`ifdef PC_SEQ_EXC_EN
            epc_q    <= 32'h0;
`endif
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            addr_err <= addr_err_n;
`ifdef PC_SEQ_EXC_EN
            epc_q    <= epc_n;
`endif
        end
    end

    // Priority: exception > eret > redirect > sequential; BOOT ignores all inputs.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        addr_err_n  = 1'b0;
        fetch_valid = (state == RUN);
        fire        = fetch_valid & fetch_ready & ~stall;
`ifdef PC_SEQ_EXC_EN
        epc_n       = epc_q;
`endif
        if (state == BOOT) begin
            state_n = RUN;
        end
`ifdef PC_SEQ_EXC_EN
        else if (exc_valid) begin
            epc_n   = exc_pc & ~32'h3;
            pc_n    = EXC_VECTOR;
            state_n = BUBBLE;
        end else if (eret_valid) begin
            pc_n    = epc_q;
            state_n = BUBBLE;
        end
`endif
        else if (redirect_valid) begin
            // Any fire this cycle is consumed; its +4 is discarded in favour of the target.
            pc_n       = redirect_target & ~32'h3;
            addr_err_n = |redirect_target[1:0];
            state_n    = BUBBLE;
        end else begin
            if (fire) begin
                pc_n = pc_plus;
            end
            state_n = RUN;
        end
    end

    assign fetch_pc = pc;
`ifdef PC_SEQ_EXC_EN
    assign epc = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; the exception sequence runs only
// when PC_SEQ_EXC_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        addr_err;
`ifdef PC_SEQ_EXC_EN
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        eret_valid;
    logic [31:0] epc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef PC_SEQ_EXC_EN
        .exc_valid       (exc_valid),
        .exc_pc          (exc_pc),
        .eret_valid      (eret_valid),
        .epc             (epc),
`endif
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .addr_err        (addr_err)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] tgt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic st, input logic rdy, input logic rv,
                       input logic [31:0] tgt, input logic ev, input logic [31:0] epc_x,
                       input logic ee);
        vec_t v;
        v.rst_n = rst_n; v.stall = st; v.ready = rdy; v.rv = rv; v.tgt = tgt;
        v.exp_valid = ev; v.exp_pc = epc_x; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic step(input logic rst_n, input logic st, input logic rdy, input logic rv,
                        input logic [31:0] tgt);
        @(negedge clk);
        reset_n = rst_n; stall = st; fetch_ready = rdy;
        redirect_valid = rv; redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_target = 32'h0;
`ifdef PC_SEQ_EXC_EN
        exc_valid = 1'b0; exc_pc = 32'h0; eret_valid = 1'b0;
`endif
        //  rst  stl  rdy  rv   target          valid  pc              err
        add(0,   0,   1,   0,   32'h0,          0,     32'h0000_3000,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_3000,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_3004,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_3008,  0);
        add(1,   0,   0,   0,   32'h0,          1,     32'h0000_3008,  0);
        add(1,   0,   0,   0,   32'h0,          1,     32'h0000_3008,  0);
        add(1,   0,   0,   0,   32'h0,          1,     32'h0000_3008,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_300C,  0);
        add(1,   1,   1,   0,   32'h0,          1,     32'h0000_300C,  0);
        add(1,   0,   1,   1,   32'h0000_3100,  0,     32'h0000_3100,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_3100,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_3104,  0);
        add(1,   0,   1,   1,   32'h0000_3102,  0,     32'h0000_3100,  1);
        add(1,   0,   0,   0,   32'h0,          1,     32'h0000_3100,  0);
        add(1,   1,   1,   1,   32'hFFFF_FFFC,  0,     32'hFFFF_FFFC,  0);
        add(1,   0,   0,   0,   32'h0,          1,     32'hFFFF_FFFC,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_0000,  0);
        add(1,   0,   1,   1,   32'h0000_0200,  0,     32'h0000_0200,  0);
        add(1,   0,   1,   1,   32'h0000_0301,  0,     32'h0000_0300,  1);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_0300,  0);
        add(1,   0,   1,   1,   32'h0000_0500,  0,     32'h0000_0500,  0);
        add(0,   0,   1,   1,   32'h0000_0600,  0,     32'h0000_3000,  0);
        add(1,   0,   1,   1,   32'h0000_0700,  1,     32'h0000_3000,  0);
        add(1,   0,   1,   0,   32'h0,          1,     32'h0000_3004,  0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
`ifdef PC_SEQ_EXC_EN
        check("reset_epc", epc, 32'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].stall, vecs[i].ready, vecs[i].rv, vecs[i].tgt);
            check($sformatf("v%0d_valid", i), {31'b0, fetch_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_pc", i), fetch_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_err", i), {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
        end

`ifdef PC_SEQ_EXC_EN
        // Exception beats a concurrent redirect; pc is 0x3004 in RUN here.
        exc_valid = 1'b1; exc_pc = 32'h0000_3010;
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_3200);
        exc_valid = 1'b0;
        check("exc_valid", {31'b0, fetch_valid}, 32'h0);
        check("exc_pc", fetch_pc, 32'h0000_4180);
        check("exc_epc", epc, 32'h0000_3010);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("exc_run_valid", {31'b0, fetch_valid}, 32'h1);
        check("exc_run_pc", fetch_pc, 32'h0000_4180);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("exc_seq_pc", fetch_pc, 32'h0000_4184);
        eret_valid = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        eret_valid = 1'b0;
        check("eret_bubble", {31'b0, fetch_valid}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("eret_valid", {31'b0, fetch_valid}, 32'h1);
        check("eret_pc", fetch_pc, 32'h0000_3010);
        // Exception and eret together: exception wins, EPC takes the aligned new PC.
        exc_valid = 1'b1; eret_valid = 1'b1; exc_pc = 32'h0000_3023;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        exc_valid = 1'b0; eret_valid = 1'b0;
        check("both_pc", fetch_pc, 32'h0000_4180);
        check("both_epc", epc, 32'h0000_3020);
        // Reset while in BUBBLE with a redirect pending.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0800);
        check("rst_bub_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_bub_pc", fetch_pc, 32'h0000_3000);
        check("rst_bub_epc", epc, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
